// File: rtl/dadda_pkg.sv
// dadda_pkg: sizing helpers shared by the pipelined Dadda multiplier
package dadda_pkg;
  function automatic int prod_w(int width);
    return 2 * width;
  endfunction
  function automatic int dadda_height(int j);
    int d = 2;
    for (int i = 1; i < j; i++) d = d * 3 / 2;
    return d;
  endfunction
  function automatic int dadda_layers(int width);
    int l = 0;
    while (dadda_height(l + 1) < width + 1) l++;
    return l;
  endfunction
  function automatic int stage_boundary(int k, int stages, int layers);
    return (2 * k * layers + stages) / (2 * stages);
  endfunction
  function automatic int regs_after(int p, int stages, int layers);
    int n = 0;
    for (int k = 1; k < stages; k++) n += (stage_boundary(k, stages, layers) == p) ? 1 : 0;
    return n;
  endfunction
endpackage

// File: rtl/dadda_layer.sv
// dadda_layer: one full-adder reduction layer taking h rows down to t rows
module dadda_layer #(
  parameter int H = 3,
  parameter int T = 2,
  parameter int PW = 8
) (
  input  logic [H-1:0][PW-1:0] rows_in,
  output logic [T-1:0][PW-1:0] rows_out
);
  localparam int F = H - T;
  logic [PW-2:0][F-1:0] cy;
  for (genvar c = 0; c < PW; c++) begin : g_c
    logic [H+F-1:0] v;
    for (genvar r = 0; r < H; r++) begin : g_r
      assign v[r] = rows_in[r][c];
    end
    if (c == 0) begin : g_lsb
      assign v[H+F-1:H] = '0;
    end else begin : g_cin
      assign v[H+F-1:H] = cy[c-1];
    end
    for (genvar k = 0; k < F; k++) begin : g_fa
      assign rows_out[k][c] = ^v[3*k +: 3];
      if (c < PW - 1) begin : g_co
        assign cy[c][k] = (v[3*k] & v[3*k+1]) | (v[3*k+2] & (v[3*k] ^ v[3*k+1]));
      end
    end
    for (genvar p = 0; p < T - F; p++) begin : g_pass
      assign rows_out[F+p][c] = v[3*F+p];
    end
  end
endmodule

// File: rtl/dadda_pipe_mult.sv
// dadda_pipe_mult: pipelined Baugh-Wooley/Dadda multiplier with valid/ready streaming
module dadda_pipe_mult
  import dadda_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int STAGES = 3,
  parameter bit SIGNED_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       is_signed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [prod_w(WIDTH)-1:0]   y
);
  localparam int PW = prod_w(WIDTH);
  localparam int L = dadda_layers(WIDTH);
  localparam int H0 = WIDTH + 1;
  logic en, sg;
  logic [L:0] vd;
  logic [H0-1:0][PW-1:0] pp;
  logic [PW-1:0] sum;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  assign vd[0] = in_valid;
  assign sg = SIGNED_EN && is_signed;
  // partial products; signed mode inverts the mixed MSB terms and adds the correction row
  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        pp[i][i+j] = (a[j] & b[i]) ^ (sg && ((i == WIDTH - 1) != (j == WIDTH - 1)));
    pp[H0-1] = sg ? {1'b1, {(WIDTH-2){1'b0}}, 1'b1, {WIDTH{1'b0}}} : '0;
  end
  for (genvar l = 0; l < L; l++) begin : g_l
    localparam int HI = l == 0 ? H0 : dadda_height(L - l + 1);
    localparam int HO = dadda_height(L - l);
    localparam int N = regs_after(l + 1, STAGES, L);
    logic [HI-1:0][PW-1:0] din;
    logic [HO-1:0][PW-1:0] lo, q;
    if (l == 0) begin : g_first
      assign din = pp;
    end else begin : g_next
      assign din = g_l[l-1].q;
    end
    dadda_layer #(.H(HI), .T(HO), .PW(PW)) u_layer (.rows_in(din), .rows_out(lo));
    if (N == 0) begin : g_wire
      assign q = lo;
      assign vd[l+1] = vd[l];
    end else begin : g_reg
      localparam int DW = N * HO * PW;
      logic [N-1:0][HO-1:0][PW-1:0] dr;
      logic [N-1:0] vr;
      // shift the layer result through this boundary's registers while the pipe moves
      always_ff @(posedge clk) begin
        if (rst) vr <= '0;
        else if (en) begin
          vr <= N'({vr, vd[l]});
          dr <= DW'({dr, lo});
        end
      end
      assign q = dr[N-1];
      assign vd[l+1] = vr[N-1];
    end
  end
  assign sum = g_l[L-1].q[0] + g_l[L-1].q[1];
  // final boundary registers the carry-propagate result and holds it while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y <= '0;
    end else if (en) begin
      out_valid <= vd[L];
      y <= vd[L] ? sum : y;
    end
  end
endmodule
